cache_lru_sched: RTL and testbench
==================================

CACHE_LRU_SCHED -- requirements
Module: cache_lru_sched

Interface
REQ-001 The block SHALL have one clock, main_clk, and a synchronous active-high reset, reset, sampled only on the rising edge of main_clk.
REQ-002 Parameter: MISS_BURST_MAX, default 4, the maximum number of consecutive miss grants while a hit request waits.
REQ-003 main_clk  in  1  system clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 hit_req  in  1  touch request: mark hit_way most-recently-used in set hit_addr.
REQ-006 hit_addr  in  11  set index for touch.
REQ-007 hit_way  in  2  way being touched.
REQ-008 hit_ack  out  1  touch granted and driven on the LRU port this cycle.
REQ-009 miss_req  in  1  victim request for set miss_addr.
REQ-010 miss_addr  in  11  set index for victim lookup.
REQ-011 miss_ack  out  1  miss accepted; miss_addr captured this cycle.
REQ-012 miss_valid  out  1  one-cycle pulse: miss_way holds the victim.
REQ-013 miss_way  out  2  victim way, valid only while miss_valid=1.
REQ-014 busy  out  1  miss sequence in progress (state not IDLE).
REQ-015 lru_addr  out  11  set address to the LRU array.
REQ-016 lru_used_index  out  2  way to mark most-recently-used.
REQ-017 lru_enable_write  out  1  commit lru_used_index for lru_addr.
REQ-018 lru_least_used_index  in  2  LRU way of the address presented one cycle earlier.

Function
REQ-019 Requesters SHALL hold req and payload stable until the matching ack; ack is a single-cycle pulse and req may drop or change in the following cycle.
REQ-020 The LRU port SHALL be owned by exactly one operation per cycle; lru_enable_write=0 in any cycle with no hit grant and no miss write.
REQ-021 FSM states: IDLE, MISS_RD, MISS_WAIT, MISS_WR.
REQ-022 IDLE, miss granted: miss_ack=1, capture miss_addr into addr_r, drive lru_addr=miss_addr, lru_enable_write=0, go to MISS_RD.
REQ-023 MISS_RD: lru_addr=addr_r, lru_enable_write=0, no grants; go to MISS_WAIT.
REQ-024 MISS_WAIT: lru_addr=addr_r, lru_enable_write=0; register lru_least_used_index into victim_r at the clock edge; go to MISS_WR.
REQ-025 MISS_WR: lru_addr=addr_r, lru_used_index=victim_r, lru_enable_write=1, miss_valid=1, miss_way=victim_r; go to IDLE.
REQ-026 Miss latency SHALL be miss_ack at cycle T, miss_valid at T+3; one miss completes at most every 4 cycles.
REQ-027 IDLE, hit granted: hit_ack=1, lru_addr=hit_addr, lru_used_index=hit_way, lru_enable_write=1 in the same cycle; remain IDLE; back-to-back hits sustain 1 per cycle.
REQ-028 Grants occur only in IDLE. With both requests present, miss SHALL win unless starve_cnt equals MISS_BURST_MAX, in which case hit wins.
REQ-029 starve_cnt, 3 bits, SHALL increment (saturating at MISS_BURST_MAX) on each miss grant made while hit_req=1, and clear on any hit grant or any IDLE cycle with hit_req=0.
REQ-030 Same-address hazards SHALL be left to the LRU array's read-through-write; no extra stall is inserted when a hit to addr_r is granted the cycle after MISS_WR.
REQ-031 Outputs in IDLE with no grant: lru_addr=0, lru_used_index=0, all acks and miss_valid 0.
REQ-032 miss_way SHALL read 0 whenever miss_valid=0.

Reset
REQ-033 While reset=1: state=IDLE, addr_r=0, victim_r=0, starve_cnt=0; hit_ack, miss_ack, miss_valid, busy, lru_enable_write all 0; no grants.
REQ-034 Reset asserted mid-miss SHALL abort the sequence: no miss_valid, no LRU write; the requester reissues after reset.
REQ-035 The first grant SHALL be possible in the first cycle with reset=0.

Verification
REQ-036 Reset, then hit_req=1, addr=0x123, way=2 -> hit_ack, lru_enable_write=1, lru_addr=0x123, lru_used_index=2 in the same cycle.
REQ-037 miss_req addr=0x7FF, model returns 3 one cycle after each read -> miss_ack T, busy T+1..T+3, miss_valid/miss_way=3 and LRU write of way 3 to 0x7FF at T+3.
REQ-038 hit_req and miss_req held continuously -> exactly 4 misses then 1 hit, repeating; no hit waits beyond 4 miss sequences.
REQ-039 Four consecutive hits to different sets -> four hit_acks on four consecutive cycles, each with matching port values.
REQ-040 reset pulsed in MISS_WAIT -> no miss_valid, no lru_enable_write; state IDLE; starve_cnt 0.
REQ-041 Miss to 0x040 followed by a hit to 0x040, way 1 -> hit granted the cycle after MISS_WR; a subsequent miss to 0x040 returns a victim other than 1.

Source files
------------

// File: rtl/cache_lru_sched_if.sv
// Request/LRU-port bundle for cache_lru_sched: hit touch, miss victim lookup and LRU array port.
interface cache_lru_sched_if;
  logic        hit_req;
  logic [10:0] hit_addr;
  logic [1:0]  hit_way;
  logic        hit_ack;
  logic        miss_req;
  logic [10:0] miss_addr;
  logic        miss_ack;
  logic        miss_valid;
  logic [1:0]  miss_way;
  logic        busy;
  logic [10:0] lru_addr;
  logic [1:0]  lru_used_index;
  logic        lru_enable_write;
  logic [1:0]  lru_least_used_index;

  modport slave (
    input  hit_req, hit_addr, hit_way, miss_req, miss_addr, lru_least_used_index,
    output hit_ack, miss_ack, miss_valid, miss_way, busy,
    output lru_addr, lru_used_index, lru_enable_write
  );

  modport master (
    output hit_req, hit_addr, hit_way, miss_req, miss_addr, lru_least_used_index,
    input  hit_ack, miss_ack, miss_valid, miss_way, busy,
    input  lru_addr, lru_used_index, lru_enable_write
  );
endinterface

// File: rtl/cache_lru_sched.sv
// Arbitrates hit touches and miss victim lookups onto a single LRU array port,
// with a bounded miss burst so a waiting hit cannot starve.
module cache_lru_sched #(
  parameter int MISS_BURST_MAX = 4
) (
  input logic               main_clk,
  input logic               reset,
  cache_lru_sched_if.slave  bus
);

  localparam logic [2:0] BURST_MAX = 3'(MISS_BURST_MAX);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS_RD   = 2'd1,
    MISS_WAIT = 2'd2,
    MISS_WR   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [10:0] r_addr;
  logic [1:0]  r_victim;
  logic [2:0]  r_starve_cnt;
  logic [2:0]  w_starve_nxt;

  logic        w_hit_grant;
  logic        w_miss_grant;
  logic        w_hit_ack;
  logic        w_miss_ack;
  logic        w_miss_valid;
  logic [1:0]  w_miss_way;
  logic        w_busy;
  logic [10:0] w_lru_addr;
  logic [1:0]  w_lru_used_index;
  logic        w_lru_enable_write;

  // State register, captured miss address, victim and starvation counter.
  always_ff @(posedge main_clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_addr       <= 11'd0;
      r_victim     <= 2'd0;
      r_starve_cnt <= 3'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      if (w_miss_grant) begin
        r_addr <= bus.miss_addr;
      end
      // Array read data for r_addr is valid during MISS_WAIT.
      if (r_state == MISS_WAIT) begin
        r_victim <= bus.lru_least_used_index;
      end
    end
  end

  // Next-state, arbitration and LRU port ownership; everything is silenced while reset is high.
  always_comb begin
    w_state_nxt        = r_state;
    w_starve_nxt       = r_starve_cnt;
    w_hit_grant        = 1'b0;
    w_miss_grant       = 1'b0;
    w_hit_ack          = 1'b0;
    w_miss_ack         = 1'b0;
    w_miss_valid       = 1'b0;
    w_miss_way         = 2'd0;
    w_busy             = 1'b0;
    w_lru_addr         = 11'd0;
    w_lru_used_index   = 2'd0;
    w_lru_enable_write = 1'b0;

    if (!reset) begin
      case (r_state)
        IDLE: begin
          if (bus.miss_req && !(bus.hit_req && (r_starve_cnt == BURST_MAX))) begin
            w_miss_grant = 1'b1;
            w_miss_ack   = 1'b1;
            w_lru_addr   = bus.miss_addr;
            w_state_nxt  = MISS_RD;
          end else if (bus.hit_req) begin
            w_hit_grant        = 1'b1;
            w_hit_ack          = 1'b1;
            w_lru_addr         = bus.hit_addr;
            w_lru_used_index   = bus.hit_way;
            w_lru_enable_write = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end

          // Count only misses that overtook a waiting hit.
          if (w_hit_grant || !bus.hit_req) begin
            w_starve_nxt = 3'd0;
          end else if (w_miss_grant && (r_starve_cnt < BURST_MAX)) begin
            w_starve_nxt = r_starve_cnt + 3'd1;
          end else begin
            w_starve_nxt = r_starve_cnt;
          end
        end
        MISS_RD: begin
          w_busy      = 1'b1;
          w_lru_addr  = r_addr;
          w_state_nxt = MISS_WAIT;
        end
        MISS_WAIT: begin
          w_busy      = 1'b1;
          w_lru_addr  = r_addr;
          w_state_nxt = MISS_WR;
        end
        MISS_WR: begin
          w_busy             = 1'b1;
          w_lru_addr         = r_addr;
          w_lru_used_index   = r_victim;
          w_lru_enable_write = 1'b1;
          w_miss_valid       = 1'b1;
          w_miss_way         = r_victim;
          w_state_nxt        = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end else begin
      w_state_nxt  = IDLE;
      w_starve_nxt = 3'd0;
    end
  end

  assign bus.hit_ack          = w_hit_ack;
  assign bus.miss_ack         = w_miss_ack;
  assign bus.miss_valid       = w_miss_valid;
  assign bus.miss_way         = w_miss_way;
  assign bus.busy             = w_busy;
  assign bus.lru_addr         = w_lru_addr;
  assign bus.lru_used_index   = w_lru_used_index;
  assign bus.lru_enable_write = w_lru_enable_write;

endmodule

// File: tb/tb_cache_lru_sched.sv
// Directed bench for cache_lru_sched with a 4-way recency-list LRU array model (read-through-write).
module tb_cache_lru_sched;

  logic main_clk;
  logic reset;
  int   checks;
  int   errors;

  cache_lru_sched_if bus_if ();

  cache_lru_sched #(.MISS_BURST_MAX(4)) dut (
    .main_clk (main_clk),
    .reset    (reset),
    .bus      (bus_if)
  );

  initial main_clk = 1'b0;
  always #5 main_clk = ~main_clk;

  // Per-set recency list: bits [1:0] = MRU way ... [7:6] = LRU way; bit 8 marks a touched set.
  bit [8:0] lru_mem [2048];

  function automatic logic [7:0] cur_order(input bit [8:0] e);
    return e[8] ? e[7:0] : 8'he4;
  endfunction

  function automatic logic [7:0] touch(input logic [7:0] o, input logic [1:0] w);
    logic [7:0] n;
    int k;
    n      = 8'd0;
    n[1:0] = w;
    k      = 1;
    for (int i = 0; i < 4; i++) begin
      if (o[2*i +: 2] != w) begin
        n[2*k +: 2] = o[2*i +: 2];
        k++;
      end
    end
    return n;
  endfunction

  function automatic logic [7:0] next_order(input bit [8:0] e, input logic we, input logic [1:0] w);
    return we ? touch(cur_order(e), w) : cur_order(e);
  endfunction

  function automatic logic [1:0] lru_of(input logic [7:0] o);
    return o[7:6];
  endfunction

  // LRU array: write applied at the edge, read data for the same address reflects that write.
  always @(posedge main_clk) begin
    lru_mem[bus_if.lru_addr] <= {1'b1, next_order(lru_mem[bus_if.lru_addr],
                                   bus_if.lru_enable_write, bus_if.lru_used_index)};
    bus_if.lru_least_used_index <= lru_of(next_order(lru_mem[bus_if.lru_addr],
                                   bus_if.lru_enable_write, bus_if.lru_used_index));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge main_clk);
    #1;
  endtask

  task automatic settle();
    @(negedge main_clk);
  endtask

  logic [10:0] h_addr [4];
  logic [1:0]  h_way  [4];
  int          p;

  initial begin
    checks = 0;
    errors = 0;
    h_addr[0] = 11'h001; h_way[0] = 2'd0;
    h_addr[1] = 11'h2AA; h_way[1] = 2'd1;
    h_addr[2] = 11'h555; h_way[2] = 2'd2;
    h_addr[3] = 11'h7FE; h_way[3] = 2'd3;

    reset            = 1'b1;
    bus_if.hit_req   = 1'b1;
    bus_if.hit_addr  = 11'h123;
    bus_if.hit_way   = 2'd2;
    bus_if.miss_req  = 1'b1;
    bus_if.miss_addr = 11'h055;
    next_cycle();
    next_cycle();
    settle();
    chk("rst_hit_ack",  32'(bus_if.hit_ack), 32'd0);
    chk("rst_miss_ack", 32'(bus_if.miss_ack), 32'd0);
    chk("rst_busy",     32'(bus_if.busy), 32'd0);
    chk("rst_we",       32'(bus_if.lru_enable_write), 32'd0);
    chk("rst_valid",    32'(bus_if.miss_valid), 32'd0);

    // First cycle out of reset: hit granted immediately.
    next_cycle();
    reset           = 1'b0;
    bus_if.miss_req = 1'b0;
    settle();
    chk("hit_ack",   32'(bus_if.hit_ack), 32'd1);
    chk("hit_we",    32'(bus_if.lru_enable_write), 32'd1);
    chk("hit_addr",  32'(bus_if.lru_addr), 32'h123);
    chk("hit_used",  32'(bus_if.lru_used_index), 32'd2);
    chk("hit_nomiss",32'(bus_if.miss_ack), 32'd0);

    // Miss to 0x7FF: ack at T, victim 3 at T+3.
    next_cycle();
    bus_if.hit_req   = 1'b0;
    bus_if.miss_req  = 1'b1;
    bus_if.miss_addr = 11'h7FF;
    settle();
    chk("m_ack",    32'(bus_if.miss_ack), 32'd1);
    chk("m_addrT",  32'(bus_if.lru_addr), 32'h7FF);
    chk("m_weT",    32'(bus_if.lru_enable_write), 32'd0);
    chk("m_busyT",  32'(bus_if.busy), 32'd0);
    next_cycle();
    bus_if.miss_req = 1'b0;
    settle();
    chk("m_busy1",  32'(bus_if.busy), 32'd1);
    chk("m_addr1",  32'(bus_if.lru_addr), 32'h7FF);
    chk("m_we1",    32'(bus_if.lru_enable_write), 32'd0);
    chk("m_valid1", 32'(bus_if.miss_valid), 32'd0);
    chk("m_way1",   32'(bus_if.miss_way), 32'd0);
    next_cycle();
    settle();
    chk("m_busy2",  32'(bus_if.busy), 32'd1);
    chk("m_we2",    32'(bus_if.lru_enable_write), 32'd0);
    chk("m_valid2", 32'(bus_if.miss_valid), 32'd0);
    next_cycle();
    settle();
    chk("m_valid3", 32'(bus_if.miss_valid), 32'd1);
    chk("m_way3",   32'(bus_if.miss_way), 32'd3);
    chk("m_we3",    32'(bus_if.lru_enable_write), 32'd1);
    chk("m_addr3",  32'(bus_if.lru_addr), 32'h7FF);
    chk("m_used3",  32'(bus_if.lru_used_index), 32'd3);
    chk("m_busy3",  32'(bus_if.busy), 32'd1);
    next_cycle();
    settle();
    chk("m_busy4",  32'(bus_if.busy), 32'd0);
    chk("m_valid4", 32'(bus_if.miss_valid), 32'd0);
    chk("m_way4",   32'(bus_if.miss_way), 32'd0);
    chk("m_we4",    32'(bus_if.lru_enable_write), 32'd0);
    chk("m_addr4",  32'(bus_if.lru_addr), 32'h000);
    chk("m_used4",  32'(bus_if.lru_used_index), 32'd0);

    // Four back-to-back hits on different sets.
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      bus_if.hit_req  = 1'b1;
      bus_if.hit_addr = h_addr[i];
      bus_if.hit_way  = h_way[i];
      settle();
      chk("b2b_ack",  32'(bus_if.hit_ack), 32'd1);
      chk("b2b_addr", 32'(bus_if.lru_addr), 32'(h_addr[i]));
      chk("b2b_used", 32'(bus_if.lru_used_index), 32'(h_way[i]));
      chk("b2b_we",   32'(bus_if.lru_enable_write), 32'd1);
    end
    next_cycle();
    bus_if.hit_req = 1'b0;
    settle();
    chk("b2b_idle_ack", 32'(bus_if.hit_ack), 32'd0);
    chk("b2b_idle_we",  32'(bus_if.lru_enable_write), 32'd0);

    // Miss to 0x040, hit to 0x040 way 1 waits and is granted right after MISS_WR.
    next_cycle();
    bus_if.miss_req  = 1'b1;
    bus_if.miss_addr = 11'h040;
    settle();
    chk("s_miss_ack", 32'(bus_if.miss_ack), 32'd1);
    next_cycle();
    bus_if.miss_req = 1'b0;
    bus_if.hit_req  = 1'b1;
    bus_if.hit_addr = 11'h040;
    bus_if.hit_way  = 2'd1;
    settle();
    chk("s_hit_rd",   32'(bus_if.hit_ack), 32'd0);
    next_cycle();
    settle();
    chk("s_hit_wait", 32'(bus_if.hit_ack), 32'd0);
    next_cycle();
    settle();
    chk("s_valid",    32'(bus_if.miss_valid), 32'd1);
    chk("s_way",      32'(bus_if.miss_way), 32'd3);
    chk("s_hit_wr",   32'(bus_if.hit_ack), 32'd0);
    next_cycle();
    settle();
    chk("s_hit_ack",  32'(bus_if.hit_ack), 32'd1);
    chk("s_hit_addr", 32'(bus_if.lru_addr), 32'h040);
    chk("s_hit_used", 32'(bus_if.lru_used_index), 32'd1);
    next_cycle();
    bus_if.hit_req   = 1'b0;
    bus_if.miss_req  = 1'b1;
    bus_if.miss_addr = 11'h040;
    settle();
    chk("s2_ack",     32'(bus_if.miss_ack), 32'd1);
    next_cycle();
    bus_if.miss_req = 1'b0;
    next_cycle();
    next_cycle();
    settle();
    chk("s2_valid",   32'(bus_if.miss_valid), 32'd1);
    chk("s2_way",     32'(bus_if.miss_way), 32'd2);

    // Both requests held: 4 miss grants (every 4 cycles) then 1 hit, repeating.
    next_cycle();
    bus_if.miss_req  = 1'b1;
    bus_if.miss_addr = 11'h100;
    bus_if.hit_req   = 1'b1;
    bus_if.hit_addr  = 11'h200;
    bus_if.hit_way   = 2'd0;
    for (int c = 0; c < 34; c++) begin
      settle();
      p = c % 17;
      chk("fair_miss", 32'(bus_if.miss_ack), ((p < 16) && (p % 4 == 0)) ? 32'd1 : 32'd0);
      chk("fair_hit",  32'(bus_if.hit_ack), (p == 16) ? 32'd1 : 32'd0);
      next_cycle();
    end
    bus_if.miss_req = 1'b0;
    bus_if.hit_req  = 1'b0;
    reset           = 1'b1;

    // Reset pulsed during MISS_WAIT aborts the miss.
    next_cycle();
    reset            = 1'b0;
    bus_if.hit_req   = 1'b1;
    bus_if.hit_addr  = 11'h300;
    bus_if.hit_way   = 2'd1;
    bus_if.miss_req  = 1'b1;
    bus_if.miss_addr = 11'h311;
    settle();
    chk("ab_miss_ack", 32'(bus_if.miss_ack), 32'd1);
    chk("ab_hit_ack",  32'(bus_if.hit_ack), 32'd0);
    next_cycle();
    bus_if.miss_req = 1'b0;
    settle();
    chk("ab_starve1",  32'(dut.r_starve_cnt), 32'd1);
    chk("ab_busy",     32'(bus_if.busy), 32'd1);
    next_cycle();
    reset = 1'b1;
    settle();
    chk("ab_rst_busy",  32'(bus_if.busy), 32'd0);
    chk("ab_rst_valid", 32'(bus_if.miss_valid), 32'd0);
    chk("ab_rst_we",    32'(bus_if.lru_enable_write), 32'd0);
    chk("ab_rst_hit",   32'(bus_if.hit_ack), 32'd0);
    next_cycle();
    reset          = 1'b0;
    bus_if.hit_req = 1'b0;
    settle();
    chk("ab_busy_after",  32'(bus_if.busy), 32'd0);
    chk("ab_valid_after", 32'(bus_if.miss_valid), 32'd0);
    chk("ab_we_after",    32'(bus_if.lru_enable_write), 32'd0);
    chk("ab_starve0",     32'(dut.r_starve_cnt), 32'd0);
    next_cycle();
    settle();
    chk("ab_valid_late",  32'(bus_if.miss_valid), 32'd0);
    chk("ab_we_late",     32'(bus_if.lru_enable_write), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
